// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port word memory between fetch and data ports
// Optional ARB_ROUND_ROBIN_EN: ties go to the port not granted most recently.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_gnt_d;
  logic                    r_we;
  logic                    r_mem_write;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_i_ack;
  logic                    r_d_ack;
  logic [DATA_WIDTH-1:0]   r_i_rdata;
  logic [DATA_WIDTH-1:0]   r_d_rdata;
  logic                    r_busy;

  logic w_i_elig;
  logic w_d_elig;
  logic w_any;
  logic w_pick_d;

  // A port whose ack is high this cycle may still show req; it has already been served.
  assign w_i_elig = i_req & ~r_i_ack;
  assign w_d_elig = d_req & ~r_d_ack;
  assign w_any    = w_i_elig | w_d_elig;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;
  assign w_pick_d = w_d_elig & (~w_i_elig | ~r_last_d);
`else
  assign w_pick_d = w_d_elig;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt_d     <= 1'b0;
      r_we        <= 1'b0;
      r_mem_write <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_d    <= 1'b1;
`endif
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_addr      <= w_pick_d ? d_addr : i_addr;
            r_we        <= w_pick_d & d_we;
            r_mem_write <= w_pick_d & d_we;
            if (w_pick_d) begin
              r_wdata <= d_wdata;
            end
            r_gnt_d     <= w_pick_d;
            r_busy      <= 1'b1;
            r_state     <= ST_ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d    <= w_pick_d;
`endif
          end
        end
        ST_ACCESS: begin
          r_mem_write <= 1'b0;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          // Memory read data is valid now: it was registered at the ACCESS->DONE edge.
          if (!r_we) begin
            if (r_gnt_d) begin
              r_d_rdata <= mem_read_data;
            end else begin
              r_i_rdata <= mem_read_data;
            end
          end
          if (r_gnt_d) begin
            r_d_ack <= 1'b1;
          end else begin
            r_i_ack <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_mem_write <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign i_ack          = r_i_ack;
  assign d_ack          = r_d_ack;
  assign i_rdata        = r_i_rdata;
  assign d_rdata        = r_d_rdata;
  assign mem_address    = r_addr;
  assign mem_write      = r_mem_write;
  assign mem_write_data = r_wdata;
  assign busy           = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - bench for mem_port_arbiter with a behavioural single-port memory
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .busy(busy)
  );

  // Word memory: unwritten words read back their preload pattern.
  logic [31:0] mem [0:63];
  logic [63:0] mem_vld = '0;

  function automatic logic [31:0] preload(input int w);
    case (w)
      4:       return 32'hDEADBEEF;
      16:      return 32'h11112222;
      default: return 32'hA0000000 + 32'(w) * 32'd4;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_address[7:2]]     <= mem_write_data;
      mem_vld[mem_address[7:2]] <= 1'b1;
    end
    mem_read_data <= mem_vld[mem_address[7:2]] ? mem[mem_address[7:2]] : preload(int'(mem_address[7:2]));
  end

  int          n_wr = 0;
  int          n_both = 0;
  logic [31:0] last_wr_addr = '0;

  always @(negedge clk) begin
    if (mem_write) begin
      n_wr         <= n_wr + 1;
      last_wr_addr <= mem_address;
    end
    if (i_ack && d_ack) n_both <= n_both + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic [31:0] exp_i = '0;
  logic [31:0] exp_d = '0;

  task automatic run_txn(input vec_t v, input string tag);
    int got, other, wr0;
    got = 0; other = 0; wr0 = n_wr;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    for (int c = 1; c <= 6 && got == 0; c++) begin
      @(negedge clk);
      if (v.is_d ? d_ack : i_ack) begin
        got = c;
        i_req = 1'b0; d_req = 1'b0;
      end
      if (v.is_d ? i_ack : d_ack) other++;
    end
    i_req = 1'b0; d_req = 1'b0;
    if (v.is_d && !v.we) exp_d = v.exp;
    if (!v.is_d) exp_i = v.exp;
    chk({tag, "_ack_cycle"}, 32'(got), 32'd3);
    chk({tag, "_i_rdata"}, i_rdata, exp_i);
    chk({tag, "_d_rdata"}, d_rdata, exp_d);
    @(negedge clk);
    chk({tag, "_ack_pulse"}, {30'd0, i_ack, d_ack}, 32'd0);
    chk({tag, "_other_ack"}, 32'(other), 32'd0);
    chk({tag, "_wr_pulses"}, 32'(n_wr - wr0), {31'd0, v.we});
    if (v.we) chk({tag, "_wr_addr"}, last_wr_addr, v.addr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_i = '0; exp_d = '0;
  endtask

  vec_t vt [8];

  initial begin
    int first, first_d, ti, td, ni, nd, k, wr0;
    int t_b2b [3];

    vt[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    vt[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0};
    vt[2] = '{1'b1, 1'b0, 32'h20, 32'h0,        32'h12345678};
    vt[3] = '{1'b0, 1'b0, 32'h20, 32'h0,        32'h12345678};
    vt[4] = '{1'b1, 1'b1, 32'h24, 32'h0BADF00D, 32'h0};
    vt[5] = '{1'b1, 1'b0, 32'h24, 32'h0,        32'h0BADF00D};
    vt[6] = '{1'b1, 1'b0, 32'h08, 32'h0,        32'hA0000008};
    vt[7] = '{1'b0, 1'b0, 32'h04, 32'h0,        32'hA0000004};

    // Reset held two cycles with both ports requesting.
    rst_n = 1'b0; i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_wdata = 32'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_ctl", {28'd0, i_ack, d_ack, mem_write, busy}, 32'd0);
      chk("rst_i_rdata", i_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_addr", mem_address, 32'd0);
      chk("rst_wdata", mem_write_data, 32'd0);
    end
    chk("rst_no_write", 32'(n_wr), 32'd0);
    rst_n = 1'b1;
    first = 0; first_d = 0;
    for (int c = 1; c <= 6 && first == 0; c++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        first = c; first_d = int'(d_ack);
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("rst_first_cycle", 32'(first), 32'd3);
`ifdef ARB_ROUND_ROBIN_EN
    chk("rst_first_port_d", 32'(first_d), 32'd0);
`else
    chk("rst_first_port_d", 32'(first_d), 32'd1);
`endif
    @(negedge clk);
    do_reset();

    for (int n = 0; n < 8; n++) run_txn(vt[n], $sformatf("vec%0d", n));

    // Contention: both held, each dropped in its ack cycle.
    do_reset();
    i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    ti = 0; td = 0; ni = 0; nd = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (i_ack) begin ni++; if (ti == 0) ti = c; i_req = 1'b0; end
      if (d_ack) begin nd++; if (td == 0) td = c; d_req = 1'b0; end
    end
`ifdef ARB_ROUND_ROBIN_EN
    chk("cont_i_cycle", 32'(ti), 32'd3);
    chk("cont_d_cycle", 32'(td), 32'd6);
`else
    chk("cont_d_cycle", 32'(td), 32'd3);
    chk("cont_i_cycle", 32'(ti), 32'd6);
`endif
    chk("cont_i_count", 32'(ni), 32'd1);
    chk("cont_d_count", 32'(nd), 32'd1);
    chk("cont_i_rdata", i_rdata, 32'hA0000000);
    chk("cont_d_rdata", d_rdata, 32'hA0000008);
    exp_i = 32'hA0000000; exp_d = 32'hA0000008;

    // Same-port back-to-back: the ack cycle itself cannot regrant that port.
    i_req = 1'b1; i_addr = 32'h0; k = 0;
    for (int c = 1; c <= 14 && k < 3; c++) begin
      @(negedge clk);
      if (i_ack) begin
        t_b2b[k] = c;
        chk($sformatf("b2b%0d_rdata", k), i_rdata, 32'hA0000000 + 32'(k) * 32'd4);
        k++;
        i_addr = 32'(k) * 32'd4;
        if (k == 3) i_req = 1'b0;
      end
    end
    i_req = 1'b0;
    chk("b2b_count", 32'(k), 32'd3);
    if (k == 3) begin
      chk("b2b_t0", 32'(t_b2b[0]), 32'd3);
      chk("b2b_t1", 32'(t_b2b[1]), 32'd7);
      chk("b2b_t2", 32'(t_b2b[2]), 32'd11);
    end
    exp_i = 32'hA0000008;

    // Reset on the edge that would start the write: nothing reaches memory.
    @(negedge clk);
    wr0 = n_wr;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFEF00D; rst_n = 1'b0;
    @(negedge clk);
    chk("rstpre_ctl", {29'd0, mem_write, busy, d_ack}, 32'd0);
    rst_n = 1'b1; d_req = 1'b0; d_we = 1'b0;
    exp_i = '0; exp_d = '0;
    chk("rstpre_no_write", 32'(n_wr - wr0), 32'd0);
    run_txn('{1'b1, 1'b0, 32'h40, 32'h0, 32'h11112222}, "rstpre_read");

    // Reset during ACCESS of a write: transaction dropped, no ack.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rstacc_in_access", {30'd0, mem_write, busy}, 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstacc_ctl", {29'd0, mem_write, busy, d_ack}, 32'd0);
    chk("rstacc_d_rdata", d_rdata, 32'd0);
    rst_n = 1'b1; d_req = 1'b0; d_we = 1'b0;
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (d_ack || i_ack || busy) nd++;
    end
    chk("rstacc_no_ack", 32'(nd), 32'd0);

    chk("never_both_acks", 32'(n_both), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
